// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
//
// Purpose
//   Owns the program counter. It fetches one instruction per memory handshake
//   and hands it to decode over a valid/ready handshake. It also drives the
//   operands of the downstream next-PC 2:1 select: pc_plus1 feeds the
//   sequential leg, and pc_sel chooses the branch-target leg. A taken branch
//   flushes any instruction that is in flight or being held for decode.
//
// Ports
//   clk            in   1            system clock, rising edge
//   rst_n          in   1            synchronous reset, active low
//   imem_addr      out  PC_WIDTH     fetch address (always the current PC)
//   imem_req       out  1            fetch request, held until imem_ack
//   imem_ack       in   1            imem_data is valid this cycle
//   imem_data      in   INSTR_WIDTH  fetched instruction word
//   instr          out  INSTR_WIDTH  registered instruction for decode
//   instr_pc       out  PC_WIDTH     registered PC of instr
//   instr_valid    out  1            instr / instr_pc are valid
//   instr_ready    in   1            decode accepts instr this cycle
//   branch_take    in   1            redirect fetch to branch_target
//   branch_target  in   PC_WIDTH     redirect address
//   pc_plus1       out  PC_WIDTH     pc + 1, wraps modulo 2^PC_WIDTH
//   pc_sel         out  1            next-PC select (1 = branch target)
// ---------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter int                     PC_WIDTH    = 8,
  parameter int                     INSTR_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic [PC_WIDTH-1:0]       imem_addr,
  output logic                      imem_req,
  input  logic                      imem_ack,
  input  logic [INSTR_WIDTH-1:0]    imem_data,
  output logic [INSTR_WIDTH-1:0]    instr,
  output logic [PC_WIDTH-1:0]       instr_pc,
  output logic                      instr_valid,
  input  logic                      instr_ready,
  input  logic                      branch_take,
  input  logic [PC_WIDTH-1:0]       branch_target,
  output logic [PC_WIDTH-1:0]       pc_plus1,
  output logic                      pc_sel
);

  // IDLE is a single bubble cycle after reset; REQ is the only state that
  // asserts imem_req; HOLD presents the fetched word until decode takes it.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]             state,       state_nxt;
  logic [PC_WIDTH-1:0]    pc,          pc_nxt;
  logic [INSTR_WIDTH-1:0] instr_nxt;
  logic [PC_WIDTH-1:0]    instr_pc_nxt;
  logic                   instr_valid_nxt;

  // The carry out of the increment is dropped, so 0xFF wraps to 0x00.
  assign pc_plus1  = pc + PC_ONE;
  assign pc_sel    = branch_take;
  assign imem_addr = pc;
  assign imem_req  = (state == REQ);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default first, so no path through the
    // case statement leaves one unassigned and infers a latch.
    state_nxt       = state;
    pc_nxt          = pc;
    instr_nxt       = instr;
    instr_pc_nxt    = instr_pc;
    instr_valid_nxt = instr_valid;

    case (state)
      IDLE: begin
        state_nxt = REQ;
      end
      REQ: begin
        if (imem_ack) begin
          instr_nxt       = imem_data;
          instr_pc_nxt    = pc;
          instr_valid_nxt = 1'b1;
          pc_nxt          = pc_plus1;
          state_nxt       = HOLD;
        end
      end
      HOLD: begin
        if (instr_ready) begin
          instr_valid_nxt = 1'b0;
          state_nxt       = REQ;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // A redirect overrides everything above. An ack in the same cycle is
    // dropped, so the memory word and the increment are both discarded. A
    // held instruction is flushed, and fetch restarts at the target. When
    // decode also asserts ready in HOLD, it has already taken the word, so
    // clearing valid here agrees with that handshake.
    if (branch_take) begin
      pc_nxt          = branch_target;
      instr_nxt       = instr;
      instr_pc_nxt    = instr_pc;
      instr_valid_nxt = 1'b0;
      state_nxt       = REQ;
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments, so
    // every register samples the values it held before the clock edge.
    if (!rst_n) begin
      // NOTE: the datapath registers instr and instr_pc are reset too,
      // because decode must observe zeros after reset, not stale data.
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      instr       <= instr_nxt;
      instr_pc    <= instr_pc_nxt;
      instr_valid <= instr_valid_nxt;
    end
  end

endmodule
